xor_32: RTL and testbench

- Registered 32-bit bitwise XOR unit for the datapath ALU, with one pipeline stage, valid tracking and result flags (zero, parity, population count).
- Sits alongside the other 32-bit logic units; its registered result feeds the ALU result mux.

---
 rtl/xor_32.sv | 87 ++++++++
 tb/tb_xor_32.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/xor_32.sv
// xor_32: registered bitwise XOR unit with valid tracking and result flags.
// One pipeline stage; zero/parity/popcount always describe the value on out.
module xor_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             zero,
  output logic             parity,
  output logic [5:0]       popcount
);

  // Number of ones in a result word; 6 bits so that 32 is representable.
  function automatic logic [5:0] count_ones(input logic [WIDTH-1:0] v);
    logic [5:0] cnt;
    cnt = 6'd0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + {5'd0, v[i]};
    end
    return cnt;
  endfunction

  // Odd parity of a result word (1 = odd number of ones).
  function automatic logic parity_of(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  logic [WIDTH-1:0] result_s;
  logic [WIDTH-1:0] out_d, out_q;
  logic             valid_d, valid_q;
  logic             zero_d, zero_q;
  logic             parity_d, parity_q;
  logic [5:0]       popcount_d, popcount_q;

  assign result_s = a ^ b;

  // Next-state: capture a fresh result and its flags on valid, otherwise hold.
  always_comb begin
    out_d      = out_q;
    zero_d     = zero_q;
    parity_d   = parity_q;
    popcount_d = popcount_q;
    valid_d    = 1'b0;
    if (in_valid) begin
      out_d      = result_s;
      zero_d     = (result_s == {WIDTH{1'b0}});
      parity_d   = parity_of(result_s);
      popcount_d = count_ones(result_s);
      valid_d    = 1'b1;
    end else begin
      out_d      = out_q;
      zero_d     = zero_q;
      parity_d   = parity_q;
      popcount_d = popcount_q;
      valid_d    = 1'b0;
    end
  end

  // Output registers; reset state is an all-zero result, so zero starts high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q      <= {WIDTH{1'b0}};
      valid_q    <= 1'b0;
      zero_q     <= 1'b1;
      parity_q   <= 1'b0;
      popcount_q <= 6'd0;
    end else begin
      out_q      <= out_d;
      valid_q    <= valid_d;
      zero_q     <= zero_d;
      parity_q   <= parity_d;
      popcount_q <= popcount_d;
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;
  assign zero      = zero_q;
  assign parity    = parity_q;
  assign popcount  = popcount_q;

endmodule

// File: tb/tb_xor_32.sv
// tb_xor_32: randomized and directed checks of xor_32 against a bench-side model.
module tb_xor_32;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic        in_valid;
  logic [31:0] out;
  logic        out_valid;
  logic        zero;
  logic        parity;
  logic [5:0]  popcount;

  int checks   = 0;
  int failures = 0;

  // Model state: the last accepted result and whether the latest edge was valid.
  logic [31:0] m_out;
  logic        m_valid;

  logic [40:0] dut_vec;
  assign dut_vec = {out, out_valid, zero, parity, popcount};

  xor_32 #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .in_valid (in_valid),
    .out      (out),
    .out_valid(out_valid),
    .zero     (zero),
    .parity   (parity),
    .popcount (popcount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count ones by repeated halving of the value as an integer.
  function automatic int ref_ones(input logic [31:0] v);
    longint x;
    int n;
    x = longint'(v);
    n = 0;
    while (x != 0) begin
      n = n + int'(x % 2);
      x = x / 2;
    end
    return n;
  endfunction

  // Expected output vector derived from the model state.
  function automatic logic [40:0] ref_vec(input logic [31:0] o, input logic v);
    int n;
    n = ref_ones(o);
    return {o, v, (o == 32'd0), (n % 2 == 1), 6'(n)};
  endfunction

  // Apply one operand set at the falling edge, step past the rising edge.
  task automatic step(input logic [31:0] av, input logic [31:0] bv, input logic v);
    @(negedge clk);
    a = av;
    b = bv;
    in_valid = v;
    @(posedge clk);
    #1;
    if (v) begin
      m_out = av ^ bv;
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    a = $urandom;
    b = $urandom;
    in_valid = 1'b1;
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dut_vec !== {32'd0, 1'b0, 1'b1, 1'b0, 6'd0}) begin
      failures++;
      $display("FAIL reset_async got=%h want=%h", dut_vec, {32'd0, 1'b0, 1'b1, 1'b0, 6'd0});
    end
    repeat (2) begin
      @(negedge clk);
      a = $urandom;
      b = $urandom;
    end
    #1;
    checks++;
    if (dut_vec !== {32'd0, 1'b0, 1'b1, 1'b0, 6'd0}) begin
      failures++;
      $display("FAIL reset_held got=%h want=%h", dut_vec, {32'd0, 1'b0, 1'b1, 1'b0, 6'd0});
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    m_out = 32'd0;
    m_valid = 1'b0;
  endtask

  task automatic test_decimal();
    step(32'd47, 32'd25, 1'b1);
    checks++;
    if (dut_vec !== {32'd54, 1'b1, 1'b0, 1'b0, 6'd4}) begin
      failures++;
      $display("FAIL decimal got=%h want=%h", dut_vec, {32'd54, 1'b1, 1'b0, 1'b0, 6'd4});
    end
  endtask

  task automatic test_binary();
    step(32'h42220225, 32'h4002028A, 1'b1);
    checks++;
    if (dut_vec !== {32'h022000AF, 1'b1, 1'b0, 1'b0, 6'd8}) begin
      failures++;
      $display("FAIL binary got=%h want=%h", dut_vec, {32'h022000AF, 1'b1, 1'b0, 1'b0, 6'd8});
    end
  endtask

  task automatic test_extremes();
    step(32'hA5A5A5A5, 32'hA5A5A5A5, 1'b1);
    checks++;
    if (dut_vec !== {32'd0, 1'b1, 1'b1, 1'b0, 6'd0}) begin
      failures++;
      $display("FAIL same_operands got=%h want=%h", dut_vec, {32'd0, 1'b1, 1'b1, 1'b0, 6'd0});
    end
    step(32'hFFFFFFFF, 32'd0, 1'b1);
    checks++;
    if (dut_vec !== {32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 6'd32}) begin
      failures++;
      $display("FAIL all_ones got=%h want=%h", dut_vec, {32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 6'd32});
    end
    step(32'd1, 32'd0, 1'b1);
    checks++;
    if (dut_vec !== {32'd1, 1'b1, 1'b0, 1'b1, 6'd1}) begin
      failures++;
      $display("FAIL odd_parity got=%h want=%h", dut_vec, {32'd1, 1'b1, 1'b0, 1'b1, 6'd1});
    end
    step(32'h12345678, 32'hFFFFFFFF, 1'b1);
    checks++;
    if (out !== 32'hEDCBA987) begin
      failures++;
      $display("FAIL invert got=%h want=%h", out, 32'hEDCBA987);
    end
  endtask

  task automatic test_hold();
    step(32'h42220225, 32'h4002028A, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step($urandom, $urandom, 1'b0);
      checks++;
      if (dut_vec !== {32'h022000AF, 1'b0, 1'b0, 1'b0, 6'd8}) begin
        failures++;
        $display("FAIL hold_%0d got=%h want=%h", i, dut_vec, {32'h022000AF, 1'b0, 1'b0, 1'b0, 6'd8});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] av [4];
    logic [31:0] bv [4];
    logic [31:0] want [4];
    av = '{32'd47, 32'd0, 32'hFFFFFFFF, 32'h42220225};
    bv = '{32'd25, 32'd0, 32'd0, 32'h4002028A};
    want = '{32'd54, 32'd0, 32'hFFFFFFFF, 32'h022000AF};
    for (int i = 0; i < 4; i++) begin
      step(av[i], bv[i], 1'b1);
      checks++;
      if (dut_vec !== ref_vec(want[i], 1'b1)) begin
        failures++;
        $display("FAIL b2b_%0d got=%h want=%h", i, dut_vec, ref_vec(want[i], 1'b1));
      end
    end
  endtask

  task automatic test_reset_mid();
    // Pulse reset between edges with a valid operand pending.
    a = 32'h0F0F0F0F;
    b = 32'h00000000;
    in_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dut_vec !== {32'd0, 1'b0, 1'b1, 1'b0, 6'd0}) begin
      failures++;
      $display("FAIL reset_mid got=%h want=%h", dut_vec, {32'd0, 1'b0, 1'b1, 1'b0, 6'd0});
    end
    @(posedge clk);
    #1;
    checks++;
    if (dut_vec !== {32'd0, 1'b0, 1'b1, 1'b0, 6'd0}) begin
      failures++;
      $display("FAIL reset_discard got=%h want=%h", dut_vec, {32'd0, 1'b0, 1'b1, 1'b0, 6'd0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    step(32'd47, 32'd25, 1'b1);
    checks++;
    if (dut_vec !== {32'd54, 1'b1, 1'b0, 1'b0, 6'd4}) begin
      failures++;
      $display("FAIL after_reset got=%h want=%h", dut_vec, {32'd54, 1'b1, 1'b0, 1'b0, 6'd4});
    end
  endtask

  task automatic test_random();
    logic [31:0] av;
    logic [31:0] bv;
    logic        v;
    for (int i = 0; i < 300; i++) begin
      av = $urandom;
      bv = $urandom;
      case ($urandom_range(0, 5))
        0: bv = av;
        1: bv = 32'd0;
        2: bv = 32'hFFFFFFFF;
        default: bv = bv;
      endcase
      v = ($urandom_range(0, 3) != 0);
      step(av, bv, v);
      checks++;
      if (dut_vec !== ref_vec(m_out, m_valid)) begin
        failures++;
        $display("FAIL random_%0d got=%h want=%h", i, dut_vec, ref_vec(m_out, m_valid));
      end
    end
  endtask

  initial begin
    m_out = 32'd0;
    m_valid = 1'b0;
    a = 32'd0;
    b = 32'd0;
    in_valid = 1'b0;
    rst_n = 1'b1;
    test_reset();
    test_decimal();
    test_binary();
    test_extremes();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
